// File: rtl/module_opseq_ctrl_pkg.sv
// Shared types and helpers for the operand-load sequencer.
package opseq_pkg;

    localparam int unsigned MAX_OPS  = 32;
    localparam int unsigned OH_IDX_W = 5;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_LOAD  = 4'b0010,
        S_EXEC  = 4'b0100,
        S_STORE = 4'b1000
    } opseq_state_t;

    function automatic logic [MAX_OPS-1:0] onehot(input logic [OH_IDX_W-1:0] idx);
        return MAX_OPS'(1) << idx;
    endfunction

endpackage

// File: rtl/module_opseq_ctrl_dwncnt.sv
// Loadable down-counter with zero flag; load has priority over decrement, saturates at 0.
module module_dwncnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld) begin
            cnt_d = ld_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/module_opseq_ctrl.sv
// Operand-load sequencer: collects N_OPS operands on rdy, waits EXEC_CYC cycles, issues result load.
module module_opseq_ctrl
    import opseq_pkg::*;
#(
    parameter int unsigned N_OPS    = 2,
    parameter int unsigned EXEC_CYC = 1,
    parameter int unsigned TIMEOUT  = 0,
    parameter int unsigned IDX_W    = (N_OPS > 1) ? $clog2(N_OPS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clr,
    output logic [N_OPS-1:0] load_op,
    output logic [IDX_W-1:0] op_idx,
    output logic             load_s,
    output logic             busy,
    output logic             done,
    output logic             err_timeout
);

    localparam int unsigned EXEC_W  = (EXEC_CYC > 1) ? $clog2(EXEC_CYC) : 1;
    localparam int unsigned TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LOAD = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit          TO_EN   = (TIMEOUT > 0);

    opseq_state_t     state_q, state_d;
    logic [IDX_W-1:0] op_idx_q, op_idx_d;
    logic             err_timeout_q, err_timeout_d;

    logic exec_ld, exec_dec, exec_zero;
    logic wait_ld, wait_dec, wait_zero;
    logic load_s_c;

    module_dwncnt #(.W(EXEC_W)) u_exec_cnt (
        .clk    (clk),
        .rst    (rst),
        .ld     (exec_ld),
        .ld_val (EXEC_W'(EXEC_CYC - 1)),
        .dec    (exec_dec),
        .zero   (exec_zero)
    );

    // Counts down the remaining rdy=0 cycles; reloaded on LOAD entry and on every accept.
    module_dwncnt #(.W(TO_W)) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .ld     (wait_ld),
        .ld_val (TO_W'(TO_LOAD)),
        .dec    (wait_dec),
        .zero   (wait_zero)
    );

    always_comb begin
        state_d       = state_q;
        op_idx_d      = op_idx_q;
        err_timeout_d = 1'b0;
        exec_ld       = 1'b0;
        exec_dec      = 1'b0;
        wait_ld       = 1'b0;
        wait_dec      = 1'b0;
        load_op       = '0;
        load_s_c      = 1'b0;

        case (state_q)
            S_IDLE: begin
                op_idx_d = '0;
                if (rdy) begin
                    state_d = S_LOAD;
                    wait_ld = 1'b1;
                end
            end
            S_LOAD: begin
                if (clr) begin
                    state_d  = S_IDLE;
                    op_idx_d = '0;
                end else if (rdy) begin
                    load_op = N_OPS'(onehot(OH_IDX_W'(op_idx_q)));
                    wait_ld = 1'b1;
                    if (op_idx_q == IDX_W'(N_OPS - 1)) begin
                        state_d  = S_EXEC;
                        op_idx_d = '0;
                        exec_ld  = 1'b1;
                    end else begin
                        op_idx_d = op_idx_q + IDX_W'(1);
                    end
                end else if (TO_EN && wait_zero) begin
                    state_d       = S_IDLE;
                    op_idx_d      = '0;
                    err_timeout_d = 1'b1;
                end else begin
                    wait_dec = TO_EN;
                end
            end
            S_EXEC: begin
                if (clr) begin
                    state_d = S_IDLE;
                end else if (exec_zero) begin
                    state_d = S_STORE;
                end else begin
                    exec_dec = 1'b1;
                end
            end
            S_STORE: begin
                state_d  = S_IDLE;
                load_s_c = !clr;
            end
            default: begin
                state_d  = S_IDLE;
                op_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            op_idx_q      <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_idx_q      <= op_idx_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign op_idx      = op_idx_q;
    assign load_s      = load_s_c;
    assign done        = load_s_c;
    assign busy        = (state_q != S_IDLE);
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_module_opseq_ctrl.sv
// Directed bench for module_opseq_ctrl over three parameter sets sharing one stimulus bus.
module tb_module_opseq_ctrl;
    import opseq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    logic [1:0] lop_a; logic       idx_a; logic ls_a, busy_a, done_a, err_a;
    logic [3:0] lop_b; logic [1:0] idx_b; logic ls_b, busy_b, done_b, err_b;
    logic [2:0] lop_c; logic [1:0] idx_c; logic ls_c, busy_c, done_c, err_c;

    module_opseq_ctrl #(.N_OPS(2), .EXEC_CYC(1), .TIMEOUT(0)) dut_a (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .load_op(lop_a), .op_idx(idx_a), .load_s(ls_a),
        .busy(busy_a), .done(done_a), .err_timeout(err_a)
    );
    module_opseq_ctrl #(.N_OPS(4), .EXEC_CYC(3), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .load_op(lop_b), .op_idx(idx_b), .load_s(ls_b),
        .busy(busy_b), .done(done_b), .err_timeout(err_b)
    );
    module_opseq_ctrl #(.N_OPS(3), .EXEC_CYC(1), .TIMEOUT(5)) dut_c (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .load_op(lop_c), .op_idx(idx_c), .load_s(ls_c),
        .busy(busy_c), .done(done_c), .err_timeout(err_c)
    );

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic drive(input logic r, input logic c);
        rdy = r;
        clr = c;
        #1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b0; clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Reset state on every instance
        do_reset();
        drive(0, 0);
        chk("rst_busy", {busy_a, busy_b, busy_c}, 0);
        chk("rst_lop",  {lop_a, lop_b, lop_c}, 0);
        chk("rst_ls",   {ls_a, ls_b, ls_c, done_a, done_b, done_c}, 0);
        chk("rst_err",  {err_a, err_b, err_c}, 0);
        chk("rst_idx",  {idx_a, idx_b, idx_c}, 0);
        nxt();

        // 1: N_OPS=2, EXEC_CYC=1, rdy held high through STORE
        for (int unsigned k = 0; k < 6; k++) begin
            drive(k < 5, 0);
            chk($sformatf("t1_lop%0d", k),  lop_a, (k == 1) ? 1 : (k == 2) ? 2 : 0);
            chk($sformatf("t1_ls%0d", k),   ls_a, k == 4);
            chk($sformatf("t1_done%0d", k), done_a, k == 4);
            chk($sformatf("t1_busy%0d", k), busy_a, (k >= 1) && (k <= 4));
            nxt();
        end

        // 2: N_OPS=4, EXEC_CYC=3, rdy every 3rd cycle; result load 4 cycles after last accept
        do_reset();
        for (int unsigned k = 0; k < 18; k++) begin
            drive((k == 0) || ((k % 3 == 0) && (k <= 12)), 0);
            chk($sformatf("t2_lop%0d", k),
                lop_b, ((k % 3 == 0) && (k >= 3) && (k <= 12)) ? (1 << (k / 3 - 1)) : 0);
            chk($sformatf("t2_ls%0d", k),   ls_b, k == 16);
            chk($sformatf("t2_busy%0d", k), busy_b, (k >= 1) && (k <= 16));
            nxt();
        end

        // 3: TIMEOUT=5, one operand then rdy=0 -> IDLE after 5 wait cycles
        do_reset();
        for (int unsigned k = 0; k < 9; k++) begin
            drive(k <= 1, 0);
            chk($sformatf("t3_lop%0d", k),  lop_c, (k == 1) ? 1 : 0);
            chk($sformatf("t3_busy%0d", k), busy_c, (k >= 1) && (k <= 6));
            chk($sformatf("t3_err%0d", k),  err_c, k == 7);
            chk($sformatf("t3_ls%0d", k),   ls_c, 0);
            nxt();
        end

        // 4: clr with rdy at op_idx=1
        do_reset();
        drive(1, 0); nxt();
        drive(1, 0); chk("t4_acc0", lop_a, 1); nxt();
        drive(1, 1);
        chk("t4_idx", idx_a, 1);
        chk("t4_lop", lop_a, 0);
        chk("t4_busy_clr", busy_a, 1);
        nxt();
        drive(0, 0);
        chk("t4_busy", busy_a, 0);
        chk("t4_idx0", idx_a, 0);
        nxt();

        // 5: reset during EXEC abandons the result load, then a clean restart
        do_reset();
        drive(1, 0); nxt();
        drive(1, 0); nxt();
        drive(1, 0); nxt();
        drive(0, 0);
        chk("t5_exec_busy", busy_a, 1);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        drive(1, 0);
        chk("t5_ls", {ls_a, done_a}, 0);
        chk("t5_busy", busy_a, 0);
        chk("t5_lop", lop_a, 0);
        chk("t5_idx", idx_a, 0);
        nxt();
        drive(0, 0);
        chk("t5_restart_idx", idx_a, 0);
        chk("t5_restart_busy", busy_a, 1);
        nxt();
        drive(1, 0);
        chk("t5_restart_lop", lop_a, 1);
        nxt();

        // 6: random rdy/clr, structural invariants on every instance
        do_reset();
        for (int unsigned k = 0; k < 10000; k++) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
            chk("r_oh_a", $countones({lop_a, ls_a}) <= 1, 1);
            chk("r_oh_b", $countones({lop_b, ls_b}) <= 1, 1);
            chk("r_oh_c", $countones({lop_c, ls_c}) <= 1, 1);
            chk("r_done", {done_a, done_b, done_c}, {ls_a, ls_b, ls_c});
            chk("r_busy_a", busy_a, dut_a.state_q != S_IDLE);
            chk("r_busy_b", busy_b, dut_b.state_q != S_IDLE);
            chk("r_busy_c", busy_c, dut_c.state_q != S_IDLE);
            if (clr) chk("r_clr", {lop_a, lop_b, lop_c, ls_a, ls_b, ls_c}, 0);
            chk("r_noto", {err_a, err_b}, 0);
            nxt();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
